// File: rtl/hex_color_entry_pkg.sv
// Shared types and helpers for keypad colour entry.
// Slot 0 in entry order is the most-significant digit.
package hex_color_entry_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        DONE
    } entry_state_t;

    function automatic int slot_lsb(
        input int count,
        input int num_digits = 6,
        input int digit_w    = 4
    );
        return (num_digits - 1 - count) * digit_w;
    endfunction

endpackage

// File: rtl/digit_slot_writer.sv
// Combinational digit insert/clear into one slot of the colour word.
// slot counts in entry order: 0 is the most-significant digit.
module digit_slot_writer
    import hex_color_entry_pkg::*;
#(
    parameter  int DIGIT_W    = 4,
    parameter  int NUM_DIGITS = 6,
    localparam int COLOR_W    = DIGIT_W * NUM_DIGITS,
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic [COLOR_W-1:0] color,
    input  logic [CNT_W-1:0]   slot,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               clear,
    output logic [COLOR_W-1:0] color_out
);

    always_comb begin
        color_out = color;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot == CNT_W'(i)) begin
                color_out[slot_lsb(i, NUM_DIGITS, DIGIT_W) +: DIGIT_W] =
                    clear ? '0 : digit;
            end
        end
    end

endmodule

// File: rtl/hex_color_entry.sv
// Keypad colour entry: fills a colour MSD-first with backspace and cancel.
// Priority each cycle is cancel > start > backspace > ready.
module hex_color_entry
    import hex_color_entry_pkg::*;
#(
    parameter  int DIGIT_W    = 4,
    parameter  int NUM_DIGITS = 6,
    localparam int COLOR_W    = DIGIT_W * NUM_DIGITS,
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               ready,
    input  logic [DIGIT_W-1:0] value,
    input  logic               backspace,
    input  logic               cancel,
    output logic [COLOR_W-1:0] final_color,
    output logic [CNT_W-1:0]   count,
    output logic               busy,
    output logic               done
);

    entry_state_t       state;
    logic               bs_sel;
    logic [CNT_W-1:0]   w_slot;
    logic [COLOR_W-1:0] next_color;

    // Backspace always clears the slot at count-1; a write fills slot count.
    always_comb begin
        bs_sel = backspace;
        w_slot = bs_sel ? count - CNT_W'(1) : count;
    end

    digit_slot_writer #(
        .DIGIT_W    (DIGIT_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_writer (
        .color     (final_color),
        .slot      (w_slot),
        .digit     (value),
        .clear     (bs_sel),
        .color_out (next_color)
    );

    always_ff @(posedge clk) begin
        if (reset || cancel) begin
            state       <= IDLE;
            final_color <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (start) begin
            state       <= ENTRY;
            final_color <= '0;
            count       <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
        end else begin
            unique case (state)
                ENTRY: begin
                    if (backspace) begin
                        if (count != '0) begin
                            final_color <= next_color;
                            count       <= count - CNT_W'(1);
                        end
                    end else if (ready) begin
                        final_color <= next_color;
                        count       <= count + CNT_W'(1);
                        if (count == CNT_W'(NUM_DIGITS - 1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (backspace) begin
                        final_color <= next_color;
                        count       <= count - CNT_W'(1);
                        state       <= ENTRY;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_color_entry.sv
// Directed bench for hex_color_entry: default 4x6 instance plus an 8x3 one.
module tb_hex_color_entry;

    logic        clk = 1'b0;
    logic        reset, start, ready, backspace, cancel;
    logic [3:0]  value;
    logic [23:0] final_color;
    logic [2:0]  count;
    logic        busy, done;

    logic        reset8, start8, ready8, backspace8, cancel8;
    logic [7:0]  value8;
    logic [23:0] final_color8;
    logic [1:0]  count8;
    logic        busy8, done8;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hex_color_entry dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ready       (ready),
        .value       (value),
        .backspace   (backspace),
        .cancel      (cancel),
        .final_color (final_color),
        .count       (count),
        .busy        (busy),
        .done        (done)
    );

    hex_color_entry #(.DIGIT_W(8), .NUM_DIGITS(3)) dut8 (
        .clk         (clk),
        .reset       (reset8),
        .start       (start8),
        .ready       (ready8),
        .value       (value8),
        .backspace   (backspace8),
        .cancel      (cancel8),
        .final_color (final_color8),
        .count       (count8),
        .busy        (busy8),
        .done        (done8)
    );

    wire [28:0] obs  = {final_color, count, busy, done};
    wire [27:0] obs8 = {final_color8, count8, busy8, done8};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        reset = 0; start = 0; ready = 0;
        backspace = 0; cancel = 0; value = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1;
        repeat (3) tick();
        reset = 0;
        vectors++;
        if (obs !== 29'h0) begin
            miscompares++;
            $display("FAIL reset_state got %h want %h", obs, 29'h0);
        end
        tick();
        vectors++;
        if (obs !== 29'h0) begin
            miscompares++;
            $display("FAIL reset_release got %h want %h", obs, 29'h0);
        end
    endtask

    task automatic test_entry;
        logic [3:0]  digs [6] = '{4'hc, 4'h5, 4'ha, 4'h0, 4'hd, 4'h8};
        logic [23:0] cols [6] = '{24'hc00000, 24'hc50000, 24'hc5a000,
                                  24'hc5a000, 24'hc5a0d0, 24'hc5a0d8};
        logic [28:0] exp;
        start = 1; tick(); start = 0;
        vectors++;
        if (obs !== {24'h0, 3'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL entry_start got %h want %h", obs,
                     {24'h0, 3'd0, 1'b1, 1'b0});
        end
        for (int i = 0; i < 6; i++) begin
            ready = 1; value = digs[i];
            tick();
            exp = {cols[i], 3'(i + 1), (i != 5), (i == 5)};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL entry_digit%0d got %h want %h", i, obs, exp);
            end
        end
        ready = 0;
    endtask

    task automatic test_done_hold;
        ready = 1; value = 4'h7; tick(); ready = 0;
        vectors++;
        if (obs !== {24'hc5a0d8, 3'd6, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL done_ignore_ready got %h want %h", obs,
                     {24'hc5a0d8, 3'd6, 1'b0, 1'b1});
        end
        tick();
        vectors++;
        if (obs !== {24'hc5a0d8, 3'd6, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL done_hold got %h want %h", obs,
                     {24'hc5a0d8, 3'd6, 1'b0, 1'b1});
        end
        backspace = 1; tick(); backspace = 0;
        vectors++;
        if (obs !== {24'hc5a0d0, 3'd5, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL done_backspace got %h want %h", obs,
                     {24'hc5a0d0, 3'd5, 1'b1, 1'b0});
        end
        ready = 1; value = 4'h3; tick(); ready = 0;
        vectors++;
        if (obs !== {24'hc5a0d3, 3'd6, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL done_rewrite got %h want %h", obs,
                     {24'hc5a0d3, 3'd6, 1'b0, 1'b1});
        end
    endtask

    task automatic test_backspace;
        start = 1; tick(); start = 0;
        backspace = 1; tick(); backspace = 0;
        vectors++;
        if (obs !== {24'h0, 3'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL bs_at_zero got %h want %h", obs,
                     {24'h0, 3'd0, 1'b1, 1'b0});
        end
        ready = 1;
        value = 4'hc; tick();
        value = 4'h5; tick();
        value = 4'ha; tick();
        ready = 0;
        vectors++;
        if (obs !== {24'hc5a000, 3'd3, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL bs_pre got %h want %h", obs,
                     {24'hc5a000, 3'd3, 1'b1, 1'b0});
        end
        backspace = 1; ready = 1; value = 4'h9; tick();
        backspace = 0; ready = 0;
        vectors++;
        if (obs !== {24'hc50000, 3'd2, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL bs_remove got %h want %h", obs,
                     {24'hc50000, 3'd2, 1'b1, 1'b0});
        end
        ready = 1; value = 4'hf; tick(); ready = 0;
        vectors++;
        if (obs !== {24'hc5f000, 3'd3, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL bs_rewrite got %h want %h", obs,
                     {24'hc5f000, 3'd3, 1'b1, 1'b0});
        end
    endtask

    task automatic test_start_ready;
        start = 1; ready = 1; value = 4'h9; tick();
        start = 0;
        vectors++;
        if (obs !== {24'h0, 3'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL start_ready got %h want %h", obs,
                     {24'h0, 3'd0, 1'b1, 1'b0});
        end
        tick(); ready = 0;
        vectors++;
        if (obs !== {24'h900000, 3'd1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL start_then_ready got %h want %h", obs,
                     {24'h900000, 3'd1, 1'b1, 1'b0});
        end
    endtask

    task automatic test_cancel;
        ready = 1; value = 4'h4; tick(); ready = 0;
        cancel = 1; start = 1; ready = 1; tick();
        cancel = 0; start = 0;
        vectors++;
        if (obs !== 29'h0) begin
            miscompares++;
            $display("FAIL cancel got %h want %h", obs, 29'h0);
        end
        value = 4'h6; tick(); ready = 0;
        vectors++;
        if (obs !== 29'h0) begin
            miscompares++;
            $display("FAIL idle_ignore got %h want %h", obs, 29'h0);
        end
        backspace = 1; tick(); backspace = 0;
        vectors++;
        if (obs !== 29'h0) begin
            miscompares++;
            $display("FAIL idle_bs got %h want %h", obs, 29'h0);
        end
    endtask

    task automatic test_reset_mid;
        start = 1; tick(); start = 0;
        ready = 1;
        value = 4'h1; tick();
        value = 4'h2; tick();
        vectors++;
        if (obs !== {24'h120000, 3'd2, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL pre_reset got %h want %h", obs,
                     {24'h120000, 3'd2, 1'b1, 1'b0});
        end
        reset = 1; start = 1; value = 4'h3; tick();
        reset = 0; start = 0; ready = 0;
        vectors++;
        if (obs !== 29'h0) begin
            miscompares++;
            $display("FAIL reset_mid got %h want %h", obs, 29'h0);
        end
    endtask

    task automatic test_param;
        logic [7:0]  digs [3] = '{8'hff, 8'h00, 8'h80};
        logic [23:0] cols [3] = '{24'hff0000, 24'hff0000, 24'hff0080};
        logic [27:0] exp;
        start8 = 1; tick(); start8 = 0;
        for (int i = 0; i < 3; i++) begin
            ready8 = 1; value8 = digs[i];
            tick();
            exp = {cols[i], 2'(i + 1), (i != 2), (i == 2)};
            vectors++;
            if (obs8 !== exp) begin
                miscompares++;
                $display("FAIL param_digit%0d got %h want %h", i, obs8, exp);
            end
        end
        ready8 = 0;
    endtask

    initial begin
        reset8 = 1; start8 = 0; ready8 = 0;
        backspace8 = 0; cancel8 = 0; value8 = '0;
        test_reset();
        reset8 = 0;
        test_entry();
        test_done_hold();
        test_backspace();
        test_start_ready();
        test_cancel();
        test_reset_mid();
        test_param();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
